// File: rtl/cv32e41p_hwloop_sequencer_pkg.sv
// cv32e41p_hwloop_sequencer_pkg: shared FSM state type and constants for the hardware-loop sequencer
package cv32e41p_hwloop_sequencer_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        JUMP_REQ = 2'd1,
        DEC      = 2'd2
    } hwlp_seq_state_e;
    localparam logic [31:0] HWLP_INSTR_BYTES = 32'd4;
endpackage

// File: rtl/cv32e41p_hwloop_match.sv
// cv32e41p_hwloop_match: per-loop last-instruction comparator with lowest-index priority
// Ports: pc_i/pc_valid_i ID-stage instruction, end_addr_i/counter_i loop registers,
//        enable_i gates evaluation, match_valid_o/match_idx_o winner, match_last_o winner counter==1.
module cv32e41p_hwloop_match
    import cv32e41p_hwloop_sequencer_pkg::*;
#(
    parameter int N_REGS     = 2,
    parameter int N_REG_BITS = $clog2(N_REGS)
) (
    input  logic [31:0]                   pc_i,
    input  logic                          pc_valid_i,
    input  logic                          enable_i,
    input  logic [N_REGS-1:0][31:0]       end_addr_i,
    input  logic [N_REGS-1:0][31:0]       counter_i,
    output logic                          match_valid_o,
    output logic [N_REG_BITS-1:0]         match_idx_o,
    output logic                          match_last_o
);
    // Scan from the highest index down so the innermost (lowest) match overwrites the rest.
    always_comb begin
        match_valid_o = 1'b0;
        match_idx_o   = '0;
        match_last_o  = 1'b0;
        for (int k = N_REGS - 1; k >= 0; k--) begin
            if (enable_i && pc_valid_i && counter_i[k] != 32'd0 &&
                pc_i == end_addr_i[k] - HWLP_INSTR_BYTES) begin
                match_valid_o = 1'b1;
                match_idx_o   = N_REG_BITS'(k);
                match_last_o  = counter_i[k] == 32'd1;
            end
        end
    end
endmodule

// File: rtl/cv32e41p_hwloop_sequencer.sv
// cv32e41p_hwloop_sequencer: decides hardware-loop jump-back or exit and issues fetch jumps and counter decrements
// Ports: pc_i/pc_valid_i ID instruction, hwlp_*_i loop register file, hwlp_we_busy_i/flush_i suppress matching,
//        fetch_ready_i jump ack; hwlp_jump_o/hwlp_targ_addr_o jump request, hwlp_dec_cnt_o/hwlp_dec_valid_o
//        one-hot decrement, busy_o not idle. All outputs registered.
module cv32e41p_hwloop_sequencer
    import cv32e41p_hwloop_sequencer_pkg::*;
#(
    parameter int N_REGS     = 2,
    parameter int N_REG_BITS = $clog2(N_REGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             pc_i,
    input  logic                    pc_valid_i,
    input  logic [N_REGS-1:0][31:0] hwlp_start_addr_i,
    input  logic [N_REGS-1:0][31:0] hwlp_end_addr_i,
    input  logic [N_REGS-1:0][31:0] hwlp_counter_i,
    input  logic                    hwlp_we_busy_i,
    input  logic                    flush_i,
    input  logic                    fetch_ready_i,
    output logic                    hwlp_jump_o,
    output logic [31:0]             hwlp_targ_addr_o,
    output logic [N_REGS-1:0]       hwlp_dec_cnt_o,
    output logic                    hwlp_dec_valid_o,
    output logic                    busy_o
);
    hwlp_seq_state_e       state, state_n;
    logic [N_REG_BITS-1:0] idx_q, idx_n;
    logic                  jump_n;
    logic [31:0]           targ_n;
    logic [N_REGS-1:0]     dec_n;
    logic                  match_valid, match_last, match_en;
    logic [N_REG_BITS-1:0] match_idx;
    // Right after a decrement pulse the counter inputs have not yet been updated.
    assign match_en = state == IDLE && !hwlp_we_busy_i && !flush_i && !hwlp_dec_valid_o;
    cv32e41p_hwloop_match #(.N_REGS(N_REGS), .N_REG_BITS(N_REG_BITS)) u_match (
        .pc_i          (pc_i),
        .pc_valid_i    (pc_valid_i),
        .enable_i      (match_en),
        .end_addr_i    (hwlp_end_addr_i),
        .counter_i     (hwlp_counter_i),
        .match_valid_o (match_valid),
        .match_idx_o   (match_idx),
        .match_last_o  (match_last)
    );
    always_comb begin
        state_n = state;
        idx_n   = idx_q;
        jump_n  = hwlp_jump_o;
        targ_n  = hwlp_targ_addr_o;
        dec_n   = '0;
        case (state)
            IDLE: if (match_valid) begin
                if (match_last) begin
                    state_n = DEC;
                    dec_n   = N_REGS'(1) << match_idx;
                end else begin
                    state_n = JUMP_REQ;
                    jump_n  = 1'b1;
                    targ_n  = hwlp_start_addr_i[match_idx];
                    idx_n   = match_idx;
                end
            end
            JUMP_REQ: if (flush_i) begin
                state_n = IDLE;
                jump_n  = 1'b0;
            end else if (fetch_ready_i) begin
                state_n = DEC;
                jump_n  = 1'b0;
                dec_n   = N_REGS'(1) << idx_q;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            idx_q            <= '0;
            hwlp_jump_o      <= 1'b0;
            hwlp_targ_addr_o <= '0;
            hwlp_dec_cnt_o   <= '0;
            hwlp_dec_valid_o <= 1'b0;
            busy_o           <= 1'b0;
        end else begin
            state            <= state_n;
            idx_q            <= idx_n;
            hwlp_jump_o      <= jump_n;
            hwlp_targ_addr_o <= targ_n;
            hwlp_dec_cnt_o   <= dec_n;
            hwlp_dec_valid_o <= |dec_n;
            busy_o           <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_cv32e41p_hwloop_sequencer.sv
// tb_cv32e41p_hwloop_sequencer: directed self-checking bench for the hardware-loop sequencer
module tb_cv32e41p_hwloop_sequencer;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      pc_i = '0;
    logic             pc_valid_i = 1'b0;
    logic [1:0][31:0] start_addr = '0;
    logic [1:0][31:0] end_addr = '0;
    logic [1:0][31:0] counter = '0;
    logic             we_busy = 1'b0;
    logic             flush = 1'b0;
    logic             fetch_ready = 1'b0;
    logic             jump;
    logic [31:0]      targ;
    logic [1:0]       dec_cnt;
    logic             dec_valid;
    logic             busy;
    int               errors = 0;
    int               checks = 0;
    always #5 clk = ~clk;
    cv32e41p_hwloop_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .pc_i              (pc_i),
        .pc_valid_i        (pc_valid_i),
        .hwlp_start_addr_i (start_addr),
        .hwlp_end_addr_i   (end_addr),
        .hwlp_counter_i    (counter),
        .hwlp_we_busy_i    (we_busy),
        .flush_i           (flush),
        .fetch_ready_i     (fetch_ready),
        .hwlp_jump_o       (jump),
        .hwlp_targ_addr_o  (targ),
        .hwlp_dec_cnt_o    (dec_cnt),
        .hwlp_dec_valid_o  (dec_valid),
        .busy_o            (busy)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    initial begin
        step();
        chk("rst_jump", 32'(jump), 0);
        chk("rst_targ", targ, 0);
        chk("rst_dec", 32'(dec_cnt), 0);
        chk("rst_decv", 32'(dec_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        // jump-back of loop 0 with ack after one stall cycle
        start_addr[0] = 32'h100; end_addr[0] = 32'h110; counter[0] = 3;
        pc_i = 32'h10C; pc_valid_i = 1'b1;
        step();
        chk("j1_jump", 32'(jump), 1);
        chk("j1_targ", targ, 32'h100);
        chk("j1_busy", 32'(busy), 1);
        chk("j1_dec", 32'(dec_cnt), 0);
        pc_valid_i = 1'b0;
        step();
        chk("j1_hold", 32'(jump), 1);
        fetch_ready = 1'b1;
        step();
        chk("j1_ack_jump", 32'(jump), 0);
        chk("j1_ack_dec", 32'(dec_cnt), 1);
        chk("j1_ack_decv", 32'(dec_valid), 1);
        chk("j1_ack_busy", 32'(busy), 1);
        fetch_ready = 1'b0;
        step();
        chk("j1_end_dec", 32'(dec_cnt), 0);
        chk("j1_end_busy", 32'(busy), 0);
        // loop exit: counter 1 decrements without jumping
        counter[0] = 1; pc_valid_i = 1'b1;
        step();
        chk("ex_jump", 32'(jump), 0);
        chk("ex_dec", 32'(dec_cnt), 1);
        chk("ex_busy", 32'(busy), 1);
        pc_valid_i = 1'b0;
        step();
        chk("ex_end_dec", 32'(dec_cnt), 0);
        chk("ex_end_busy", 32'(busy), 0);
        // nested loops sharing an end address: loop 0 wins
        start_addr[0] = 32'h200; end_addr[0] = 32'h120; counter[0] = 2;
        start_addr[1] = 32'h300; end_addr[1] = 32'h120; counter[1] = 5;
        pc_i = 32'h11C; pc_valid_i = 1'b1;
        step();
        chk("nest_jump", 32'(jump), 1);
        chk("nest_targ", targ, 32'h200);
        pc_valid_i = 1'b0; fetch_ready = 1'b1;
        step();
        chk("nest_dec", 32'(dec_cnt), 2'b01);
        fetch_ready = 1'b0;
        step();
        chk("nest_end_dec", 32'(dec_cnt), 0);
        // held request then flush beating a same-cycle ack
        pc_valid_i = 1'b1;
        step();
        chk("fl_jump", 32'(jump), 1);
        pc_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fl_hold_jump", 32'(jump), 1);
            chk("fl_hold_targ", targ, 32'h200);
            chk("fl_hold_dec", 32'(dec_cnt), 0);
        end
        flush = 1'b1; fetch_ready = 1'b1;
        step();
        chk("fl_jump_off", 32'(jump), 0);
        chk("fl_busy", 32'(busy), 0);
        chk("fl_dec", 32'(dec_cnt), 0);
        flush = 1'b0; fetch_ready = 1'b0;
        step();
        chk("fl_after_dec", 32'(dec_cnt), 0);
        // suppressed matches: write busy, inactive counter, flush
        counter[1] = 0;
        start_addr[0] = 32'h100; end_addr[0] = 32'h110; counter[0] = 3;
        pc_i = 32'h10C; pc_valid_i = 1'b1; we_busy = 1'b1;
        step();
        chk("wb_jump", 32'(jump), 0);
        chk("wb_busy", 32'(busy), 0);
        we_busy = 1'b0; counter[0] = 0;
        step();
        chk("c0_jump", 32'(jump), 0);
        chk("c0_dec", 32'(dec_cnt), 0);
        counter[0] = 3; flush = 1'b1;
        step();
        chk("fm_jump", 32'(jump), 0);
        chk("fm_dec", 32'(dec_cnt), 0);
        flush = 1'b0; pc_valid_i = 1'b0;
        // end address 0 wraps to a last instruction at 0xFFFFFFFC
        start_addr[0] = 32'h40; end_addr[0] = 32'h0; counter[0] = 4;
        pc_i = 32'hFFFF_FFFC; pc_valid_i = 1'b1;
        step();
        chk("wrap_jump", 32'(jump), 1);
        chk("wrap_targ", targ, 32'h40);
        pc_valid_i = 1'b0;
        // asynchronous reset in the middle of a request
        #2 rst = 1'b1;
        #1;
        chk("arst_jump", 32'(jump), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_targ", targ, 0);
        #2 rst = 1'b0;
        step();
        chk("arst_idle", 32'(busy), 0);
        start_addr[0] = 32'h100; end_addr[0] = 32'h110; counter[0] = 2;
        pc_i = 32'h10C; pc_valid_i = 1'b1;
        step();
        chk("post_jump", 32'(jump), 1);
        chk("post_targ", targ, 32'h100);
        pc_valid_i = 1'b0; fetch_ready = 1'b1;
        step();
        chk("post_dec", 32'(dec_cnt), 1);
        chk("post_decv", 32'(dec_valid), 1);
        fetch_ready = 1'b0;
        step();
        chk("post_busy", 32'(busy), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
